reg_en: RTL and testbench

//  - Generic parameterized D register with write enable and asynchronous active-low reset.
//  - It is the storage primitive behind every inter-stage pipeline register.
//  - Stage registers (e.g. ID/EX) instantiate one per field: PC, IS, IMM, SR1/SR2, CSR, ctrl, mux-select.
//  - Flush/bubble is applied upstream by masking din; this block has no clear input.

---
 rtl/pipe_pkg.sv | 22 ++
 rtl/reg_en.sv | 52 +++++
 tb/tb_reg_en.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared field widths for the inter-stage pipeline registers.
//                Stage registers pass these as the WIDTH of each reg_en.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Architectural data-path width (PC, IS, IMM, SR1/SR2, CSR fields)
    localparam int XLEN       = 32;

    // Control bundles carried down the pipe
    localparam int CTRL_EX_W  = 16;
    localparam int CTRL_MEM_W = 8;
    localparam int CTRL_WB_W  = 8;

    // Concatenated operand/forwarding mux selects
    localparam int MUX_SEL_W  = 24;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/reg_en.sv
`default_nettype none
// ============================================================================
//  Module      : reg_en
//  Description : Parameterized D register with write enable and asynchronous
//                active-low reset. Storage primitive behind every pipeline
//                stage register; flush/bubble is applied upstream on din.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_en
    import pipe_pkg::*;
#(
    parameter int              WIDTH   = XLEN,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wen,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // Storage: reset dominates, otherwise capture on enable, else hold.
    // dout is the flop output itself so there is no path from din/wen.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= RST_VAL;
        end else if (wen) begin
            dout <= din;
        end
    end

`ifndef SYNTHESIS
    // A zero-width register is meaningless; stop elaboration early.
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("reg_en: WIDTH must be >= 1");
        end
    endgenerate

    // An unknown enable would leave the stored value undefined.
    a_wen_known : assert property (
        @(posedge clk) disable iff (!rstn) !$isunknown(wen)
    ) else $error("reg_en: wen is X/Z at clock edge");

    // Capturing unknown data poisons every downstream stage.
    a_din_known : assert property (
        @(posedge clk) disable iff (!rstn) wen |-> !$isunknown(din)
    ) else $error("reg_en: din is X/Z while wen=1");
`endif

endmodule : reg_en
`default_nettype wire

// File: tb/tb_reg_en.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_en
//  Description : Self-checking bench for reg_en: a 32-bit instance with
//                RST_VAL=0 and an 8-bit instance with RST_VAL=8'h3C, directed
//                scenarios followed by randomized traffic against a reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_en;

    localparam logic [31:0] c_rst_a = 32'h0000_0000;
    localparam logic [7:0]  c_rst_b = 8'h3C;

    logic        clk = 1'b0;
    logic        rstn_a, wen_a;
    logic [31:0] din_a, dout_a;
    logic        rstn_b, wen_b;
    logic [7:0]  din_b, dout_b;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    reg_en #(.WIDTH(32), .RST_VAL(c_rst_a)) dut_a (
        .clk  (clk),
        .rstn (rstn_a),
        .wen  (wen_a),
        .din  (din_a),
        .dout (dout_a)
    );

    reg_en #(.WIDTH(8), .RST_VAL(c_rst_b)) dut_b (
        .clk  (clk),
        .rstn (rstn_b),
        .wen  (wen_b),
        .din  (din_b),
        .dout (dout_b)
    );

    // Reset asserted with writes requested and clock running
    task automatic test_reset();
        #2;
        rstn_a = 1'b0; wen_a = 1'b1; din_a = 32'hFFFF_FFFF;
        rstn_b = 1'b0; wen_b = 1'b1; din_b = 8'hFF;
        #1;
        chk_cnt++;
        if (dout_a !== c_rst_a) $display("FAIL reset_async: dout=%h expected %h", dout_a, c_rst_a);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (dout_a !== c_rst_a) $display("FAIL reset_hold_a[%0d]: dout=%h expected %h", i, dout_a, c_rst_a);
            else pass_cnt++;
            chk_cnt++;
            if (dout_b !== c_rst_b) $display("FAIL reset_hold_b[%0d]: dout=%h expected %h", i, dout_b, c_rst_b);
            else pass_cnt++;
        end
    endtask

    // Single write with exactly one cycle of latency
    task automatic test_write();
        @(negedge clk);
        rstn_a = 1'b1; wen_a = 1'b1; din_a = 32'hDEAD_BEEF;
        #1;
        chk_cnt++;
        if (dout_a !== c_rst_a) $display("FAIL write_early: dout=%h expected %h", dout_a, c_rst_a);
        else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++;
        if (dout_a !== 32'hDEAD_BEEF) $display("FAIL write: dout=%h expected %h", dout_a, 32'hDEAD_BEEF);
        else pass_cnt++;
    endtask

    // Enable low keeps the stored value regardless of din
    task automatic test_hold();
        @(negedge clk);
        wen_a = 1'b0; din_a = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (dout_a !== 32'hDEAD_BEEF) $display("FAIL hold[%0d]: dout=%h expected %h", i, dout_a, 32'hDEAD_BEEF);
            else pass_cnt++;
        end
    endtask

    // Reset dropped between edges acts immediately; release with wen=0 holds
    task automatic test_async_reset();
        @(negedge clk);
        wen_a = 1'b1; din_a = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        chk_cnt++;
        if (dout_a !== 32'hA5A5_A5A5) $display("FAIL async_pre: dout=%h expected %h", dout_a, 32'hA5A5_A5A5);
        else pass_cnt++;
        din_a = 32'h0F0F_0F0F;
        #1;
        rstn_a = 1'b0;
        #1;
        chk_cnt++;
        if (dout_a !== c_rst_a) $display("FAIL async_mid: dout=%h expected %h", dout_a, c_rst_a);
        else pass_cnt++;
        @(negedge clk);
        rstn_a = 1'b1; wen_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (dout_a !== c_rst_a) $display("FAIL async_release[%0d]: dout=%h expected %h", i, dout_a, c_rst_a);
            else pass_cnt++;
        end
    endtask

    // Narrow instance with a non-zero reset value
    task automatic test_params();
        chk_cnt++;
        if (dout_b !== c_rst_b) $display("FAIL param_reset: dout=%h expected %h", dout_b, c_rst_b);
        else pass_cnt++;
        @(negedge clk);
        rstn_b = 1'b1; wen_b = 1'b1; din_b = 8'hFF;
        @(posedge clk); #1;
        chk_cnt++;
        if (dout_b !== 8'hFF) $display("FAIL param_ff: dout=%h expected %h", dout_b, 8'hFF);
        else pass_cnt++;
        din_b = 8'h00;
        @(posedge clk); #1;
        chk_cnt++;
        if (dout_b !== 8'h00) $display("FAIL param_00: dout=%h expected %h", dout_b, 8'h00);
        else pass_cnt++;
        wen_b = 1'b0;
    endtask

    // Consecutive writes appear one per cycle
    task automatic test_back_to_back();
        @(negedge clk);
        wen_a = 1'b1; din_a = 32'd1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            chk_cnt++;
            if (dout_a !== 32'(i)) $display("FAIL b2b[%0d]: dout=%h expected %h", i, dout_a, 32'(i));
            else pass_cnt++;
            din_a = 32'(i + 1);
        end
        wen_a = 1'b0;
    endtask

    // Reset falling in the same instant as a write edge wins
    task automatic test_simultaneous();
        @(negedge clk);
        wen_a = 1'b1; din_a = 32'h5555_5555;
        @(posedge clk); #1;
        chk_cnt++;
        if (dout_a !== 32'h5555_5555) $display("FAIL simul_pre: dout=%h expected %h", dout_a, 32'h5555_5555);
        else pass_cnt++;
        din_a = 32'hAAAA_AAAA;
        @(posedge clk);
        rstn_a = 1'b0;
        #1;
        chk_cnt++;
        if (dout_a !== c_rst_a) $display("FAIL simul: dout=%h expected %h", dout_a, c_rst_a);
        else pass_cnt++;
        @(negedge clk);
        rstn_a = 1'b1; wen_a = 1'b0;
    endtask

    // Random traffic on both instances against a value-level reference
    task automatic test_random();
        logic [31:0] exp_a = dout_a === c_rst_a ? c_rst_a : 32'h0000_0000;
        logic [7:0]  exp_b = 8'h00;
        exp_a = c_rst_a;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rstn_a = ($urandom_range(15) != 0);
            rstn_b = ($urandom_range(15) != 0);
            wen_a  = 1'($urandom_range(1));
            wen_b  = 1'($urandom_range(1));
            din_a  = $urandom;
            din_b  = 8'($urandom);
            if (!rstn_a) exp_a = c_rst_a;
            if (!rstn_b) exp_b = c_rst_b;
            #1;
            chk_cnt++;
            if (dout_a !== exp_a) $display("FAIL rand_pre_a[%0d]: dout=%h expected %h", n, dout_a, exp_a);
            else pass_cnt++;
            chk_cnt++;
            if (dout_b !== exp_b) $display("FAIL rand_pre_b[%0d]: dout=%h expected %h", n, dout_b, exp_b);
            else pass_cnt++;
            @(posedge clk); #1;
            if (rstn_a && wen_a) exp_a = din_a;
            if (rstn_b && wen_b) exp_b = din_b;
            chk_cnt++;
            if (dout_a !== exp_a) $display("FAIL rand_a[%0d]: dout=%h expected %h", n, dout_a, exp_a);
            else pass_cnt++;
            chk_cnt++;
            if (dout_b !== exp_b) $display("FAIL rand_b[%0d]: dout=%h expected %h", n, dout_b, exp_b);
            else pass_cnt++;
        end
    endtask

    initial begin
        rstn_a = 1'b1; wen_a = 1'b0; din_a = '0;
        rstn_b = 1'b1; wen_b = 1'b0; din_b = '0;
        test_reset();
        test_write();
        test_hold();
        test_async_reset();
        test_params();
        test_back_to_back();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: sim time=%0t limit=%0d", $time, 200000);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_reg_en
`default_nettype wire
